// File: rtl/jogo_pkg.sv
// Shared definitions for the tic-tac-toe turn controller: state and result
// codes, the eight winning lines, and a cell-index decoder.
package jogo_pkg;

    typedef enum logic [2:0] {
        E_INICIAL  = 3'd0,
        E_LIMPA    = 3'd1,
        E_ESPERA   = 3'd2,
        E_REGISTRA = 3'd3,
        E_AVALIA   = 3'd4,
        E_FIM      = 3'd5
    } estado_t;

    // One-hot FSM encoding; the Moore outputs hang off single flops.
    typedef enum logic [5:0] {
        S_INICIAL  = 6'b000001,
        S_LIMPA    = 6'b000010,
        S_ESPERA   = 6'b000100,
        S_REGISTRA = 6'b001000,
        S_AVALIA   = 6'b010000,
        S_FIM      = 6'b100000
    } fsm_t;

    localparam logic [1:0] VENC_NENHUM = 2'b00;
    localparam logic [1:0] VENC_X      = 2'b01;
    localparam logic [1:0] VENC_O      = 2'b10;
    localparam logic [1:0] VENC_EMPATE = 2'b11;

    localparam logic [7:0][8:0] LINHAS = {
        9'h054, 9'h111, 9'h124, 9'h092,
        9'h049, 9'h1C0, 9'h038, 9'h007
    };

    // Indices above 8 fall off the top and decode to zero.
    function automatic logic [8:0] onehot9(input logic [3:0] c);
        onehot9 = 9'd1 << c;
    endfunction

endpackage

// File: rtl/detector_vitoria.sv
// Combinational win detector: flags a mask that covers any winning line.
module detector_vitoria
    import jogo_pkg::*;
(
    input  logic [8:0] mask,
    output logic       vitoria
);

    always_comb begin
        vitoria = 1'b0;
        for (int i = 0; i < 8; i++) begin
            if ((mask & LINHAS[i]) == LINHAS[i]) vitoria = 1'b1;
        end
    end

endmodule

// File: rtl/controle_jogada.sv
// Turn controller: arbitrates X/O moves, drives the board-register clear and
// enables, handles turn timeout, and detects win or draw.
module controle_jogada
    import jogo_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 1000
) (
    input  logic       clock,
    input  logic       clear_n,
    input  logic       iniciar,
    input  logic       req_x,
    input  logic       req_o,
    input  logic [3:0] celula_x,
    input  logic [3:0] celula_o,
    input  logic [8:0] q_x,
    input  logic [8:0] q_o,
    output logic       clr_reg,
    output logic       en_x,
    output logic       en_o,
    output logic [8:0] d_reg,
    output logic       vez,
    output logic       fim,
    output logic [1:0] vencedor,
    output logic       erro_jogada,
    output logic       timeout,
    output logic [2:0] estado
);

    localparam int TW = $clog2(TIMEOUT_CYCLES);
    localparam logic [TW-1:0] TIMER_MAX = TW'(TIMEOUT_CYCLES - 1);

    fsm_t          st;
    logic [TW-1:0] timer;
    logic [3:0]    cel;

    logic [8:0] ocupado;
    logic       req_atual;
    logic [3:0] cel_req;
    logic       cel_ok;
    logic [8:0] mask_jogador;
    logic       vitoria;

    assign ocupado      = q_x | q_o;
    assign req_atual    = vez ? req_o : req_x;
    assign cel_req      = vez ? celula_o : celula_x;
    assign cel_ok       = (cel_req < 4'd9) && ((ocupado & onehot9(cel_req)) == 9'd0);
    assign mask_jogador = vez ? q_o : q_x;
    assign d_reg        = (st == S_REGISTRA) ? (mask_jogador | onehot9(cel)) : 9'd0;

    detector_vitoria u_detector (
        .mask    (mask_jogador),
        .vitoria (vitoria)
    );

    always_ff @(posedge clock or negedge clear_n) begin
        if (!clear_n) begin
            st          <= S_INICIAL;
            timer       <= '0;
            cel         <= '0;
            vez         <= 1'b0;
            fim         <= 1'b0;
            vencedor    <= VENC_NENHUM;
            clr_reg     <= 1'b0;
            en_x        <= 1'b0;
            en_o        <= 1'b0;
            erro_jogada <= 1'b0;
            timeout     <= 1'b0;
        end else begin
            clr_reg     <= 1'b0;
            en_x        <= 1'b0;
            en_o        <= 1'b0;
            erro_jogada <= 1'b0;
            timeout     <= 1'b0;
            case (st)
                S_INICIAL: begin
                    if (iniciar) begin
                        st       <= S_LIMPA;
                        clr_reg  <= 1'b1;
                        vez      <= 1'b0;
                        timer    <= '0;
                        fim      <= 1'b0;
                        vencedor <= VENC_NENHUM;
                    end
                end
                S_LIMPA: begin
                    st    <= S_ESPERA;
                    timer <= '0;
                end
                S_ESPERA: begin
                    if (iniciar) begin
                        st       <= S_LIMPA;
                        clr_reg  <= 1'b1;
                        vez      <= 1'b0;
                        timer    <= '0;
                        fim      <= 1'b0;
                        vencedor <= VENC_NENHUM;
                    end else if (req_atual && cel_ok) begin
                        cel  <= cel_req;
                        st   <= S_REGISTRA;
                        en_x <= ~vez;
                        en_o <= vez;
                    end else begin
                        // A rejected move leaves the turn clock running, so it
                        // can coincide with expiry and both pulses fire.
                        if (req_atual) erro_jogada <= 1'b1;
                        if (timer == TIMER_MAX) begin
                            timeout <= 1'b1;
                            vez     <= ~vez;
                            timer   <= '0;
                        end else begin
                            timer <= timer + TW'(1);
                        end
                    end
                end
                S_REGISTRA: begin
                    st <= S_AVALIA;
                end
                S_AVALIA: begin
                    if (vitoria) begin
                        st       <= S_FIM;
                        fim      <= 1'b1;
                        vencedor <= vez ? VENC_O : VENC_X;
                    end else if (ocupado == 9'h1FF) begin
                        st       <= S_FIM;
                        fim      <= 1'b1;
                        vencedor <= VENC_EMPATE;
                    end else begin
                        st    <= S_ESPERA;
                        vez   <= ~vez;
                        timer <= '0;
                    end
                end
                S_FIM: begin
                    if (iniciar) begin
                        st       <= S_LIMPA;
                        clr_reg  <= 1'b1;
                        vez      <= 1'b0;
                        timer    <= '0;
                        fim      <= 1'b0;
                        vencedor <= VENC_NENHUM;
                    end
                end
                default: st <= S_INICIAL;
            endcase
        end
    end

    always_comb begin
        estado = E_INICIAL;
        case (st)
            S_INICIAL:  estado = E_INICIAL;
            S_LIMPA:    estado = E_LIMPA;
            S_ESPERA:   estado = E_ESPERA;
            S_REGISTRA: estado = E_REGISTRA;
            S_AVALIA:   estado = E_AVALIA;
            S_FIM:      estado = E_FIM;
            default:    estado = E_INICIAL;
        endcase
    end

endmodule

// File: tb/tb_controle_jogada.sv
// Directed bench for controle_jogada with a behavioural pair of board registers.
module tb_controle_jogada;

    logic       clock = 1'b0;
    logic       clear_n = 1'b0;
    logic       iniciar = 1'b0;
    logic       req_x = 1'b0;
    logic       req_o = 1'b0;
    logic [3:0] celula_x = 4'd0;
    logic [3:0] celula_o = 4'd0;
    logic [8:0] q_x = 9'd0;
    logic [8:0] q_o = 9'd0;
    logic       clr_reg, en_x, en_o, vez, fim, erro_jogada, timeout;
    logic [8:0] d_reg;
    logic [1:0] vencedor;
    logic [2:0] estado;

    int checks = 0;
    int errors = 0;

    controle_jogada #(.TIMEOUT_CYCLES(4)) dut (
        .clock       (clock),
        .clear_n     (clear_n),
        .iniciar     (iniciar),
        .req_x       (req_x),
        .req_o       (req_o),
        .celula_x    (celula_x),
        .celula_o    (celula_o),
        .q_x         (q_x),
        .q_o         (q_o),
        .clr_reg     (clr_reg),
        .en_x        (en_x),
        .en_o        (en_o),
        .d_reg       (d_reg),
        .vez         (vez),
        .fim         (fim),
        .vencedor    (vencedor),
        .erro_jogada (erro_jogada),
        .timeout     (timeout),
        .estado      (estado)
    );

    always #5 clock = ~clock;

    // Board registers are only cleared by clr_reg, never by clear_n.
    always_ff @(posedge clock) begin
        if (clr_reg) begin
            q_x <= 9'd0;
            q_o <= 9'd0;
        end else begin
            if (en_x) q_x <= d_reg;
            if (en_o) q_o <= d_reg;
        end
    end

    task automatic tick;
        @(posedge clock);
        #1;
    endtask

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic start;
        iniciar = 1'b1;
        tick;
        iniciar = 1'b0;
    endtask

    task automatic play(input bit p, input logic [3:0] c);
        if (p) begin
            req_o = 1'b1;
            celula_o = c;
        end else begin
            req_x = 1'b1;
            celula_x = c;
        end
        tick;
        req_x = 1'b0;
        req_o = 1'b0;
        tick;
        tick;
    endtask

    initial begin
        // Reset state
        tick;
        tick;
        check("rst_estado", 16'(estado), 16'd0);
        check("rst_vez", 16'(vez), 16'd0);
        check("rst_fim", 16'(fim), 16'd0);
        check("rst_vencedor", 16'(vencedor), 16'd0);
        check("rst_outs", {11'd0, clr_reg, en_x, en_o, erro_jogada, timeout}, 16'd0);
        check("rst_d_reg", 16'(d_reg), 16'd0);
        clear_n = 1'b1;
        tick;
        check("idle_estado", 16'(estado), 16'd0);

        // Start and first move
        start;
        check("limpa_estado", 16'(estado), 16'd1);
        check("limpa_clr", 16'(clr_reg), 16'd1);
        tick;
        check("espera_estado", 16'(estado), 16'd2);
        check("espera_clr", 16'(clr_reg), 16'd0);
        check("espera_vez", 16'(vez), 16'd0);
        req_x = 1'b1;
        celula_x = 4'd4;
        tick;
        req_x = 1'b0;
        check("reg_estado", 16'(estado), 16'd3);
        check("reg_en", {14'd0, en_x, en_o}, 16'b10);
        check("reg_d", 16'(d_reg), 16'h010);
        tick;
        check("aval_estado", 16'(estado), 16'd4);
        check("aval_en_x", 16'(en_x), 16'd0);
        check("aval_q_x", 16'(q_x), 16'h010);
        tick;
        check("m1_estado", 16'(estado), 16'd2);
        check("m1_vez", 16'(vez), 16'd1);

        // Restart mid-game from ESPERA, then X wins on the top row
        start;
        check("restart_estado", 16'(estado), 16'd1);
        tick;
        check("restart_vez", 16'(vez), 16'd0);
        check("restart_board", 16'(q_x | q_o), 16'd0);
        check("restart_venc", 16'(vencedor), 16'd0);
        play(0, 4'd0);
        play(1, 4'd3);
        play(0, 4'd1);
        play(1, 4'd4);
        play(0, 4'd2);
        check("xwin_estado", 16'(estado), 16'd5);
        check("xwin_fim", 16'(fim), 16'd1);
        check("xwin_venc", 16'(vencedor), 16'b01);
        check("xwin_q_x", 16'(q_x), 16'h007);
        req_x = 1'b1;
        celula_x = 4'd5;
        tick;
        req_x = 1'b0;
        check("fim_no_en", {14'd0, en_x, en_o}, 16'd0);
        check("fim_hold", 16'(estado), 16'd5);
        tick;
        check("fim_q_x", 16'(q_x), 16'h007);

        // Wrong-player request, illegal moves, timer keeps running through errors
        start;
        tick;
        play(0, 4'd0);
        play(1, 4'd1);
        req_o = 1'b1;
        celula_o = 4'd2;
        tick;
        req_o = 1'b0;
        check("ign_o_estado", 16'(estado), 16'd2);
        check("ign_o_err", {14'd0, erro_jogada, en_o}, 16'd0);
        req_x = 1'b1;
        celula_x = 4'd0;
        tick;
        check("err_occupied", 16'(erro_jogada), 16'd1);
        celula_x = 4'd9;
        tick;
        req_x = 1'b0;
        check("err_range", 16'(erro_jogada), 16'd1);
        check("err_vez", 16'(vez), 16'd0);
        check("err_estado", 16'(estado), 16'd2);
        tick;
        check("err_drop", 16'(erro_jogada), 16'd0);
        check("err_then_to", 16'(timeout), 16'd1);
        check("err_then_vez", 16'(vez), 16'd1);

        // Pure timeout, then a valid move in the expiry cycle
        start;
        tick;
        tick;
        tick;
        tick;
        check("to_early", 16'(timeout), 16'd0);
        tick;
        check("to_pulse", 16'(timeout), 16'd1);
        check("to_vez", 16'(vez), 16'd1);
        tick;
        check("to_drop", 16'(timeout), 16'd0);
        tick;
        tick;
        req_o = 1'b1;
        celula_o = 4'd4;
        tick;
        req_o = 1'b0;
        check("mv_exp_to", 16'(timeout), 16'd0);
        check("mv_exp_estado", 16'(estado), 16'd3);
        check("mv_exp_en", {14'd0, en_x, en_o}, 16'b01);
        check("mv_exp_d", 16'(d_reg), 16'h010);
        tick;
        tick;
        check("mv_exp_vez", 16'(vez), 16'd0);
        check("mv_exp_q_o", 16'(q_o), 16'h010);

        // Draw: X0 O1 X2 O4 X3 O5 X7 O6 X8
        start;
        tick;
        play(0, 4'd0);
        play(1, 4'd1);
        play(0, 4'd2);
        play(1, 4'd4);
        play(0, 4'd3);
        play(1, 4'd5);
        play(0, 4'd7);
        play(1, 4'd6);
        check("draw_pre_fim", 16'(fim), 16'd0);
        play(0, 4'd8);
        check("draw_venc", 16'(vencedor), 16'b11);
        check("draw_fim", 16'(fim), 16'd1);
        check("draw_q_x", 16'(q_x), 16'h18D);
        check("draw_q_o", 16'(q_o), 16'h072);

        // Ninth move completes the left column: winner, not draw
        start;
        tick;
        play(0, 4'd0);
        play(1, 4'd1);
        play(0, 4'd2);
        play(1, 4'd4);
        play(0, 4'd3);
        play(1, 4'd5);
        play(0, 4'd7);
        play(1, 4'd8);
        play(0, 4'd6);
        check("win9_board", 16'(q_x | q_o), 16'h1FF);
        check("win9_venc", 16'(vencedor), 16'b01);

        // O wins on the middle row
        start;
        tick;
        play(0, 4'd0);
        play(1, 4'd3);
        play(0, 4'd1);
        play(1, 4'd4);
        play(0, 4'd8);
        play(1, 4'd5);
        check("owin_venc", 16'(vencedor), 16'b10);
        check("owin_vez", 16'(vez), 16'd1);

        // Asynchronous reset while a write is in flight
        start;
        tick;
        req_x = 1'b1;
        celula_x = 4'd4;
        tick;
        req_x = 1'b0;
        check("arst_pre_en", 16'(en_x), 16'd1);
        clear_n = 1'b0;
        #1;
        check("arst_estado", 16'(estado), 16'd0);
        check("arst_outs", {11'd0, clr_reg, en_x, en_o, erro_jogada, timeout}, 16'd0);
        check("arst_d_reg", 16'(d_reg), 16'd0);
        check("arst_vez", 16'(vez), 16'd0);
        tick;
        clear_n = 1'b1;
        tick;
        check("arst_idle", 16'(estado), 16'd0);
        check("arst_no_write", 16'(q_x), 16'h000);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/controle_jogada.md
# controle_jogada

Turn controller for the tic-tac-toe board datapath. Sequences the two 9-bit board registers (X mask and O mask, one bit per cell) and arbitrates moves between the two player inputs, granting only the player whose turn it is. Rejects illegal moves and passes the turn on timeout. Detects win and draw, and drives the registers' clear and enable lines.

## Interface
- `TIMEOUT_CYCLES`, default 1000: cycles a player has to move before the turn passes; minimum 2.
- `clock`  in  1  rising-edge clock.
- `clear_n`  in  1  asynchronous, active-low reset.
- `iniciar`  in  1  start/restart pulse.
- `req_x`, `req_o`  in  1 each  move request from player X / O; one-cycle pulse.
- `celula_x`, `celula_o`  in  4 each  target cell index for X / O; valid range 0..8.
- `q_x`, `q_o`  in  9 each  current contents of the X / O board registers.
- `clr_reg`  out  1  active-high clear to both board registers.
- `en_x`, `en_o`  out  1 each  load enable to the X / O register.
- `d_reg`  out  9  data to the enabled register.
- `vez`  out  1  turn: 0 = X, 1 = O.
- `fim`  out  1  game over.
- `vencedor`  out  2  result: 00 none, 01 X, 10 O, 11 draw.
- `erro_jogada`  out  1  one-cycle pulse when a move is rejected.
- `timeout`  out  1  one-cycle pulse when a turn is forfeited.
- `estado`  out  3  encoded state, for debug.

## Operation
States and their `estado` codes: INICIAL=0, LIMPA=1, ESPERA=2, REGISTRA=3, AVALIA=4, FIM=5.
- **INICIAL**: all outputs idle. `iniciar` → LIMPA.
- **LIMPA**: `clr_reg`=1. Sets `vez`=0, timer=0, `vencedor`=00, `fim`=0. Unconditionally → ESPERA.
- **ESPERA**: timer increments every cycle. Priority order, highest first:
  1. `iniciar` → LIMPA.
  2. Request from the current player with cell<9 and `(q_x|q_o)[cell]`=0: latch the cell, → REGISTRA.
  3. Request from the current player with cell≥9 or an occupied cell: `erro_jogada` pulse, stay in ESPERA; the timer is not reset.
  4. Timer = `TIMEOUT_CYCLES`-1: `timeout` pulse, toggle `vez`, timer=0.
- Requests from the non-current player are ignored, with no error pulse. A valid move and a timeout in the same cycle: the move wins and no timeout pulse is issued.
- **REGISTRA**: drives the enable of the current player only. `d_reg` = that player's mask OR onehot(latched cell). Unconditionally → AVALIA.
- **AVALIA**: evaluates the updated mask of the player who just moved against the 8 winning lines.
  - Win → FIM, `vencedor` = 01 or 10.
  - Otherwise, if `(q_x|q_o)`=9'h1FF → FIM, `vencedor`=11. A win on the ninth move reports the winner, not a draw.
  - Otherwise toggle `vez`, timer=0, → ESPERA.
- **FIM**: `fim`=1; `vencedor` and `vez` are held. `iniciar` → LIMPA. Requests are ignored.
- `iniciar` is ignored in REGISTRA and AVALIA; a started move always completes its write.
- **Reset values**: state INICIAL, `vez`=0, `vencedor`=00, `fim`=0, `clr_reg`/`en_x`/`en_o`/`erro_jogada`/`timeout`=0, `d_reg`=0, timer=0, latched cell=0.
- **Reset mid-game**: the controller returns to INICIAL. The board registers are cleared at the next LIMPA, not by `clear_n`.

## Timing
- Requests are sampled at the rising edge in ESPERA.
- A valid request at edge k gives:
  - REGISTRA for cycle k..k+1, with the enable high.
  - The register loaded at edge k+1.
  - AVALIA in cycle k+1..k+2, seeing the new `q_*`.
  - ESPERA or FIM from edge k+2.
- Three cycles from request to acceptance of the next player's move.
- `clr_reg`, `en_x` and `en_o` are Moore outputs decoded from the state only. They must be glitch-free: a one-hot internal state register; `estado` is derived from it.
- `erro_jogada` and `timeout` are registered and rise the cycle after the triggering edge.
- Timeout fires exactly `TIMEOUT_CYCLES` cycles after entering ESPERA with no valid move.
- Timer width is `$clog2(TIMEOUT_CYCLES)`.

## Structure
- **Shared package** (`jogo_pkg`):
  - state codes;
  - `vencedor` codes;
  - the 8 winning-line constants, 9 bits each: 0x007, 0x038, 0x1C0, 0x049, 0x092, 0x124, 0x111, 0x054.
- **Sub-module** `detector_vitoria`: combinational; 9-bit mask → 1-bit win, computed as the OR over lines of ((mask & line) == line).

## Test plan
- Reset, then `iniciar` → `clr_reg` high for exactly 1 cycle, then ESPERA with `vez`=0. X plays cell 4 → `en_x` pulse with `d_reg`=0x010, then `vez`=1.
- X plays 0, 1, 2 interleaved with O plays 3, 4 → after X's third move, `fim`=1 and `vencedor`=01, with X mask 0x007. Further requests produce no enables.
- O requests while `vez`=0 → no response. X requests an occupied cell, then cell 9 → two `erro_jogada` pulses; `vez` stays 0.
- With `TIMEOUT_CYCLES`=4 and no input → `timeout` pulse 4 cycles after entering ESPERA, and `vez` toggles. A valid move in the expiry cycle → no timeout pulse.
- Sequence X0 O1 X2 O4 X3 O5 X7 O6 X8 → after the ninth move, `vencedor`=11. A separate sequence whose ninth move completes a line reports the winner instead.
- `iniciar` during ESPERA mid-game → LIMPA with board cleared, `vez`=0, `vencedor`=00. `clear_n` low during REGISTRA → INICIAL immediately with all outputs at reset values.
